equation_tracker: RTL and testbench

EQUATION_TRACKER -- requirements
Module: equation_tracker

---
 rtl/equation_tracker.sv | 186 ++++++++++++++++++
 tb/tb_equation_tracker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/equation_tracker.sv
// Equation tracker: collects NUMBER, OPERATOR, NUMBER from on-screen hits and evaluates the equation.
// It also tracks lives lost to water, using a per-frame cooldown, and latches game-over.
module equation_tracker #(
    parameter int unsigned NUMBERS         = 3,
    parameter int unsigned LIVES           = 3,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [NUMBERS-1:0]     SingleHitPulse,
    input  logic [4*NUMBERS-1:0]   numberValues,
    input  logic [1:0]             operandHit,
    input  logic                   waterCollision,
    input  logic [7:0]             targetValue,
    output logic [7:0]             score,
    output logic [1:0]             lives,
    output logic [7:0]             result,
    output logic [1:0]             phase,
    output logic                   equationDone,
    output logic                   success,
    output logic                   respawnNumbers,
    output logic                   gameOver
);

    typedef enum logic [1:0] {
        S_NUM1 = 2'd0,
        S_OP   = 2'd1,
        S_NUM2 = 2'd2,
        S_EVAL = 2'd3
    } state_t;

    localparam logic [1:0] LIVES_INIT    = LIVES[1:0];
    localparam logic [5:0] COOLDOWN_INIT = COOLDOWN_FRAMES[5:0];

    state_t      state_q, state_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic        op_q, op_d;          // 0 = plus, 1 = minus
    logic [7:0]  result_q, result_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [5:0]  cool_q, cool_d;
    logic        lost_q, lost_d;
    logic        over_q, over_d;

    logic        num_hit;
    logic [3:0]  pick_val;
    logic        water_accept;
    logic        eval_active;
    logic        eval_success;
    logic [7:0]  sum_ext;
    logic [7:0]  diff_ext;

    // Scan from the top down so the lowest set index overwrites the others.
    always_comb begin
        pick_val = 4'd0;
        for (int i = NUMBERS - 1; i >= 0; i--) begin
            if (SingleHitPulse[i]) begin
                pick_val = numberValues[4*i +: 4];
            end
        end
    end

    assign num_hit      = |SingleHitPulse;
    assign water_accept = waterCollision && (cool_q == 6'd0) && !lost_q && !over_q;
    assign eval_active  = (state_q == S_EVAL) && !water_accept && !over_q;
    assign eval_success = eval_active && (result_q == targetValue);

    // Both operands are zero-extended, so 8-bit subtraction yields the signed difference.
    assign sum_ext  = {4'd0, a_q} + {4'd0, pick_val};
    assign diff_ext = {4'd0, a_q} - {4'd0, pick_val};

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_NUM1;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            op_q     <= 1'b0;
            result_q <= 8'd0;
            score_q  <= 8'd0;
            lives_q  <= LIVES_INIT;
            cool_q   <= 6'd0;
            lost_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            cool_q   <= cool_d;
            lost_q   <= lost_d;
            over_q   <= over_d;
        end
    end

    // Next-state logic: water acceptance overrides any equation progress.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        if (over_q) begin
            state_d = state_q;
        end else if (water_accept) begin
            state_d = S_NUM1;
            a_d     = 4'd0;
            op_d    = 1'b0;
        end else begin
            case (state_q)
                S_NUM1: begin
                    if (num_hit) begin
                        a_d     = pick_val;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (|operandHit) begin
                        op_d    = !operandHit[0];
                        state_d = S_NUM2;
                    end
                end
                S_NUM2: begin
                    if (num_hit) begin
                        b_d      = pick_val;
                        result_d = op_q ? diff_ext : sum_ext;
                        state_d  = S_EVAL;
                    end
                end
                S_EVAL: begin
                    state_d = S_NUM1;
                end
                default: begin
                    state_d = S_NUM1;
                end
            endcase
        end
    end

    // Score, lives, cooldown and game-over bookkeeping.
    always_comb begin
        score_d = score_q;
        lives_d = lives_q;
        cool_d  = cool_q;
        lost_d  = lost_q;
        over_d  = over_q;
        if (!over_q) begin
            if (eval_success && (score_q != 8'hFF)) begin
                score_d = score_q + 8'd1;
            end
            if (water_accept) begin
                if (lives_q != 2'd0) begin
                    lives_d = lives_q - 2'd1;
                end
                if (lives_q <= 2'd1) begin
                    over_d = 1'b1;
                end
                lost_d = 1'b1;
                cool_d = COOLDOWN_INIT;
            end else if (startOfFrame) begin
                lost_d = 1'b0;
                if (cool_q != 6'd0) begin
                    cool_d = cool_q - 6'd1;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        phase          = state_q;
        equationDone   = eval_active;
        success        = eval_success;
        respawnNumbers = eval_active || water_accept;
        gameOver       = over_q;
        score          = score_q;
        lives          = lives_q;
        result         = result_q;
    end

endmodule

// File: tb/tb_equation_tracker.sv
// Directed bench for equation_tracker: equations, ignored hits, water/cooldown, game-over and reset.
module tb_equation_tracker;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [2:0]  SingleHitPulse;
    logic [11:0] numberValues;
    logic [1:0]  operandHit;
    logic        waterCollision;
    logic [7:0]  targetValue;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [7:0]  result;
    logic [1:0]  phase;
    logic        equationDone;
    logic        success;
    logic        respawnNumbers;
    logic        gameOver;

    int checks = 0;
    int fails  = 0;

    equation_tracker dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .SingleHitPulse (SingleHitPulse),
        .numberValues   (numberValues),
        .operandHit     (operandHit),
        .waterCollision (waterCollision),
        .targetValue    (targetValue),
        .score          (score),
        .lives          (lives),
        .result         (result),
        .phase          (phase),
        .equationDone   (equationDone),
        .success        (success),
        .respawnNumbers (respawnNumbers),
        .gameOver       (gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_num(input logic [2:0] bits);
        @(negedge clk); SingleHitPulse = bits;
        @(negedge clk); SingleHitPulse = 3'b000;
        #1;
    endtask

    task automatic pulse_op(input logic [1:0] bits);
        @(negedge clk); operandHit = bits;
        @(negedge clk); operandHit = 2'b00;
        #1;
    endtask

    task automatic frame_tick();
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0; startOfFrame = 1'b0; SingleHitPulse = 3'b000; operandHit = 2'b00;
        waterCollision = 1'b0; targetValue = 8'd8; numberValues = {4'd7, 4'd5, 4'd3};
        #12;
        checks++; if (score !== 8'd0) begin fails++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if (lives !== 2'd3) begin fails++; $display("FAIL reset_lives got %0d want 3", lives); end
        checks++; if (result !== 8'd0) begin fails++; $display("FAIL reset_result got %0h want 0", result); end
        checks++; if (phase !== 2'd0) begin fails++; $display("FAIL reset_phase got %0d want 0", phase); end
        checks++; if ({equationDone, success, respawnNumbers, gameOver} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {equationDone, success, respawnNumbers, gameOver}); end
        @(negedge clk); resetN = 1'b1;
    endtask

    task automatic test_success();
        pulse_num(3'b001);
        checks++; if (phase !== 2'd1) begin fails++; $display("FAIL succ_phase_op got %0d want 1", phase); end
        pulse_op(2'b01);
        checks++; if (phase !== 2'd2) begin fails++; $display("FAIL succ_phase_num2 got %0d want 2", phase); end
        pulse_num(3'b010);
        checks++; if (phase !== 2'd3) begin fails++; $display("FAIL succ_phase_eval got %0d want 3", phase); end
        checks++; if (result !== 8'd8) begin fails++; $display("FAIL succ_result got %0h want 08", result); end
        checks++; if ({equationDone, success, respawnNumbers} !== 3'b111) begin
            fails++; $display("FAIL succ_pulses got %b want 111", {equationDone, success, respawnNumbers}); end
        checks++; if (score !== 8'd0) begin fails++; $display("FAIL succ_score_early got %0d want 0", score); end
        @(negedge clk); #1;
        checks++; if (score !== 8'd1) begin fails++; $display("FAIL succ_score got %0d want 1", score); end
        checks++; if (phase !== 2'd0) begin fails++; $display("FAIL succ_back_num1 got %0d want 0", phase); end
        checks++; if ({equationDone, success} !== 2'b00) begin fails++; $display("FAIL succ_one_cycle got %b want 00", {equationDone, success}); end
    endtask

    task automatic test_fail();
        pulse_num(3'b100);
        pulse_op(2'b10);
        pulse_num(3'b001);
        checks++; if (result !== 8'd4) begin fails++; $display("FAIL fail_result got %0h want 04", result); end
        checks++; if ({equationDone, success, respawnNumbers} !== 3'b101) begin
            fails++; $display("FAIL fail_pulses got %b want 101", {equationDone, success, respawnNumbers}); end
        @(negedge clk); #1;
        checks++; if (score !== 8'd1) begin fails++; $display("FAIL fail_score got %0d want 1", score); end
    endtask

    task automatic test_multi_hit();
        pulse_num(3'b110);
        pulse_op(2'b01);
        pulse_num(3'b001);
        checks++; if (result !== 8'd8) begin fails++; $display("FAIL multi_result got %0h want 08", result); end
        checks++; if (success !== 1'b1) begin fails++; $display("FAIL multi_success got %b want 1", success); end
        @(negedge clk); #1;
        checks++; if (score !== 8'd2) begin fails++; $display("FAIL multi_score got %0d want 2", score); end
        numberValues = {4'd7, 4'd15, 4'd0};
        pulse_num(3'b001);
        pulse_op(2'b10);
        pulse_num(3'b010);
        checks++; if (result !== 8'hF1) begin fails++; $display("FAIL neg_result got %0h want f1", result); end
        checks++; if ({equationDone, success} !== 2'b10) begin fails++; $display("FAIL neg_pulses got %b want 10", {equationDone, success}); end
        @(negedge clk); #1;
        checks++; if (score !== 8'd2) begin fails++; $display("FAIL neg_score got %0d want 2", score); end
        numberValues = {4'd7, 4'd5, 4'd3};
    endtask

    task automatic test_ignored();
        pulse_op(2'b01);
        checks++; if (phase !== 2'd0) begin fails++; $display("FAIL ign_op_in_num1 got %0d want 0", phase); end
        pulse_num(3'b010);
        pulse_num(3'b100);
        checks++; if (phase !== 2'd1) begin fails++; $display("FAIL ign_num_in_op got %0d want 1", phase); end
        pulse_op(2'b11);
        pulse_op(2'b10);
        checks++; if (phase !== 2'd2) begin fails++; $display("FAIL ign_op_in_num2 got %0d want 2", phase); end
        @(negedge clk); SingleHitPulse = 3'b001;
        @(negedge clk); SingleHitPulse = 3'b100; operandHit = 2'b01;
        #1;
        checks++; if (result !== 8'd8) begin fails++; $display("FAIL ign_plus_wins got %0h want 08", result); end
        @(negedge clk); SingleHitPulse = 3'b000; operandHit = 2'b00;
        #1;
        checks++; if (phase !== 2'd0) begin fails++; $display("FAIL ign_num_in_eval got %0d want 0", phase); end
        checks++; if (score !== 8'd3) begin fails++; $display("FAIL ign_score got %0d want 3", score); end
    endtask

    task automatic test_water_priority();
        pulse_num(3'b001);
        pulse_op(2'b01);
        @(negedge clk); SingleHitPulse = 3'b010; waterCollision = 1'b1;
        #1;
        checks++; if ({equationDone, respawnNumbers} !== 2'b01) begin
            fails++; $display("FAIL wp_pulses got %b want 01", {equationDone, respawnNumbers}); end
        @(negedge clk); SingleHitPulse = 3'b000; waterCollision = 1'b0;
        #1;
        checks++; if (phase !== 2'd0) begin fails++; $display("FAIL wp_phase got %0d want 0", phase); end
        checks++; if (lives !== 2'd2) begin fails++; $display("FAIL wp_lives got %0d want 2", lives); end
        checks++; if (result !== 8'd8) begin fails++; $display("FAIL wp_result got %0h want 08", result); end
        checks++; if (score !== 8'd3) begin fails++; $display("FAIL wp_score got %0d want 3", score); end
    endtask

    task automatic test_mid_reset();
        pulse_num(3'b001);
        #2 resetN = 1'b0;
        #1;
        checks++; if ({score, lives, result, phase} !== {8'd0, 2'd3, 8'd0, 2'd0}) begin
            fails++; $display("FAIL mr_values got %h want %h", {score, lives, result, phase}, {8'd0, 2'd3, 8'd0, 2'd0}); end
        @(negedge clk); resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if ({equationDone, success, respawnNumbers, gameOver} !== 4'b0000) begin
                fails++; $display("FAIL mr_no_pulse got %b want 0000", {equationDone, success, respawnNumbers, gameOver}); end
        end
    endtask

    task automatic test_cooldown();
        logic [1:0] want;
        @(negedge clk); waterCollision = 1'b1;
        #1;
        checks++; if (respawnNumbers !== 1'b1) begin fails++; $display("FAIL cd_first_accept got %b want 1", respawnNumbers); end
        @(negedge clk); #1;
        checks++; if (lives !== 2'd2) begin fails++; $display("FAIL cd_first_lives got %0d want 2", lives); end
        for (int k = 1; k <= 40; k++) begin
            frame_tick();
            want = (k < 30) ? 2'd2 : 2'd1;
            checks++; if (lives !== want) begin fails++; $display("FAIL cd_frame_%0d got %0d want %0d", k, lives, want); end
        end
        waterCollision = 1'b0;
    endtask

    task automatic test_game_over();
        repeat (20) frame_tick();
        pulse_num(3'b001);
        pulse_op(2'b01);
        pulse_num(3'b010);
        @(negedge clk); #1;
        checks++; if (score !== 8'd1) begin fails++; $display("FAIL go_pre_score got %0d want 1", score); end
        @(negedge clk); waterCollision = 1'b1;
        @(negedge clk); waterCollision = 1'b0;
        #1;
        checks++; if ({lives, gameOver, phase} !== {2'd0, 1'b1, 2'd0}) begin
            fails++; $display("FAIL go_enter got %b want 00100", {lives, gameOver, phase}); end
        pulse_num(3'b001);
        checks++; if (phase !== 2'd0) begin fails++; $display("FAIL go_frozen_phase got %0d want 0", phase); end
        pulse_op(2'b01);
        pulse_num(3'b010);
        checks++; if ({equationDone, success, respawnNumbers} !== 3'b000) begin
            fails++; $display("FAIL go_no_pulse got %b want 000", {equationDone, success, respawnNumbers}); end
        repeat (3) frame_tick();
        @(negedge clk); waterCollision = 1'b1;
        #1;
        checks++; if (respawnNumbers !== 1'b0) begin fails++; $display("FAIL go_water_ignored got %b want 0", respawnNumbers); end
        @(negedge clk); waterCollision = 1'b0;
        #1;
        checks++; if ({score, lives, gameOver} !== {8'd1, 2'd0, 1'b1}) begin
            fails++; $display("FAIL go_hold got %h want %h", {score, lives, gameOver}, {8'd1, 2'd0, 1'b1}); end
        #2 resetN = 1'b0;
        #1;
        checks++; if ({lives, gameOver, score} !== {2'd3, 1'b0, 8'd0}) begin
            fails++; $display("FAIL go_reset got %h want %h", {lives, gameOver, score}, {2'd3, 1'b0, 8'd0}); end
        @(negedge clk); resetN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_success();
        test_fail();
        test_multi_hit();
        test_ignored();
        test_water_priority();
        test_mid_reset();
        test_cooldown();
        test_game_over();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
